// File: rtl/env_act_pkg.sv
`default_nettype none
// ============================================================================
// env_act_pkg : shared types and channel constants for the actuator scheduler
// Rev 1.0
// ============================================================================
package env_act_pkg;

  localparam int NUM_CH = 4;

  localparam logic [1:0] CH_HEAT  = 2'd0;
  localparam logic [1:0] CH_COOL  = 2'd1;
  localparam logic [1:0] CH_HUM   = 2'd2;
  localparam logic [1:0] CH_DEHUM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ON       = 2'd1,
    ST_COOLDOWN = 2'd2
  } state_t;

  function automatic logic [NUM_CH-1:0] ch_mask(input logic [1:0] id);
    return NUM_CH'(1) << id;
  endfunction

endpackage
`default_nettype wire

// File: rtl/env_act_rr_pick.sv
`default_nettype none
// ============================================================================
// env_act_rr_pick : combinational round-robin picker, searches from last_id+1
// Rev 1.0
// ============================================================================
module env_act_rr_pick
  import env_act_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [1:0]        last_id,
  output logic              found,
  output logic [1:0]        pick_id
);

  logic [1:0] w_idx;

  // The 2-bit index wraps naturally, so the last slot visited is last_id itself.
  always_comb begin
    found   = 1'b0;
    pick_id = last_id;
    w_idx   = last_id;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_idx = last_id + 2'(i);
      if (!found && req[w_idx]) begin
        found   = 1'b1;
        pick_id = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/env_act_sched.sv
`default_nettype none
// ============================================================================
// env_act_sched : single-grant actuator scheduler with min-on/max-on/min-off
// Rev 1.0
// ============================================================================
module env_act_sched
  import env_act_pkg::*;
#(
  parameter int MIN_ON_S  = 5,
  parameter int MAX_ON_S  = 20,
  parameter int MIN_OFF_S = 3,
  parameter int TIMER_W   = 8
) (
  input  logic               pclk,
  input  logic               presetn,
  input  logic               tick_1s,
  input  logic [3:0]         req,
  output logic [3:0]         grant,
  output logic [1:0]         active_id,
  output logic               cooldown,
  output logic [TIMER_W-1:0] elapsed_s
);

  localparam logic [TIMER_W-1:0] C_MIN_ON  = TIMER_W'(MIN_ON_S);
  localparam logic [TIMER_W-1:0] C_MAX_ON  = TIMER_W'(MAX_ON_S);
  localparam logic [TIMER_W-1:0] C_MIN_OFF = TIMER_W'(MIN_OFF_S);
  localparam logic [TIMER_W-1:0] C_SAT     = '1;

  state_t             r_state;
  logic               w_found;
  logic [1:0]         w_pick_id;
  logic [TIMER_W-1:0] w_elapsed_inc;
  logic               w_others;
  logic               w_release;

  env_act_rr_pick u_pick (
    .req     (req),
    .last_id (active_id),
    .found   (w_found),
    .pick_id (w_pick_id)
  );

  assign w_elapsed_inc = (tick_1s && (elapsed_s != C_SAT)) ? elapsed_s + TIMER_W'(1) : elapsed_s;
  assign w_others      = |(req & ~ch_mask(active_id));
  // Release only once min-on is served: owner gone, or max-on reached under contention.
  assign w_release     = (elapsed_s >= C_MIN_ON) &&
                         (!req[active_id] || ((elapsed_s >= C_MAX_ON) && w_others));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      grant     <= '0;
      active_id <= CH_DEHUM;
      cooldown  <= 1'b0;
      elapsed_s <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          grant <= '0;
          if (w_found) begin
            r_state   <= ST_ON;
            grant     <= ch_mask(w_pick_id);
            active_id <= w_pick_id;
            elapsed_s <= '0;
          end
        end
        ST_ON: begin
          if (w_release) begin
            r_state   <= ST_COOLDOWN;
            grant     <= '0;
            cooldown  <= 1'b1;
            elapsed_s <= '0;
          end else begin
            elapsed_s <= w_elapsed_inc;
          end
        end
        ST_COOLDOWN: begin
          if (elapsed_s >= C_MIN_OFF) begin
            r_state  <= ST_IDLE;
            cooldown <= 1'b0;
          end else begin
            elapsed_s <= w_elapsed_inc;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          grant    <= '0;
          cooldown <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_env_act_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_env_act_sched : scenario tasks with a grant scoreboard and a random soak
// Rev 1.0
// ============================================================================
module tb_env_act_sched;

  localparam int MIN_ON_S = 5;

  logic       pclk;
  logic       presetn;
  logic       tick_1s;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] active_id;
  logic       cooldown;
  logic [7:0] elapsed_s;

  int         n_pass;
  int         n_total;
  logic [3:0] exp_q[$];
  logic [1:0] model_last;
  logic [3:0] e;

  env_act_sched #(
    .MIN_ON_S  (5),
    .MAX_ON_S  (20),
    .MIN_OFF_S (3),
    .TIMER_W   (8)
  ) dut (
    .pclk      (pclk),
    .presetn   (presetn),
    .tick_1s   (tick_1s),
    .req       (req),
    .grant     (grant),
    .active_id (active_id),
    .cooldown  (cooldown),
    .elapsed_s (elapsed_s)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (presetn) begin
      assert ($onehot0(grant)) else $error("grant not onehot0: %b", grant);
      assert (!(cooldown && (grant != 4'b0))) else $error("grant %b during cooldown", grant);
    end
  end

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  task automatic do_tick;
    tick_1s = 1'b1;
    step();
    tick_1s = 1'b0;
  endtask

  // Nearest channel above last wins; walked from the far end so the closest overwrites.
  function automatic logic [1:0] rr_ref(input logic [3:0] r, input logic [1:0] last);
    int idx;
    logic [1:0] res;
    res = last;
    for (int k = 4; k >= 1; k--) begin
      idx = (int'(last) + k) % 4;
      if (r[idx]) res = 2'(idx);
    end
    return res;
  endfunction

  task automatic test_reset;
    presetn = 1'b0; req = 4'b0; tick_1s = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    n_total++; if (grant !== 4'b0) $display("FAIL reset_grant: got %b want 0000", grant); else n_pass++;
    n_total++; if (active_id !== 2'd3) $display("FAIL reset_active_id: got %0d want 3", active_id); else n_pass++;
    n_total++; if (cooldown !== 1'b0) $display("FAIL reset_cooldown: got %b want 0", cooldown); else n_pass++;
    n_total++; if (elapsed_s !== 8'd0) $display("FAIL reset_elapsed: got %0d want 0", elapsed_s); else n_pass++;
    presetn = 1'b1;
    model_last = 2'd3;
    step();
  endtask

  task automatic test_first_grant;
    req = 4'b0101;
    exp_q.push_back(4'b0001); model_last = 2'd0;
    step();
    e = exp_q.pop_front();
    n_total++; if (grant !== e) $display("FAIL first_grant: got %b want %b", grant, e); else n_pass++;
    n_total++; if (active_id !== 2'd0) $display("FAIL first_active_id: got %0d want 0", active_id); else n_pass++;
  endtask

  task automatic test_min_on_hold;
    req = 4'b0001;
    repeat (2) do_tick();
    req = 4'b0000;
    repeat (3) do_tick();
    n_total++; if (grant !== 4'b0001 || elapsed_s !== 8'd5)
      $display("FAIL min_on_hold: got grant %b elapsed %0d want 0001 elapsed 5", grant, elapsed_s); else n_pass++;
    step();
    n_total++; if (grant !== 4'b0 || cooldown !== 1'b1 || elapsed_s !== 8'd0)
      $display("FAIL min_on_release: got grant %b cd %b elapsed %0d want 0000 1 0", grant, cooldown, elapsed_s); else n_pass++;
    repeat (3) do_tick();
    n_total++; if (cooldown !== 1'b1 || elapsed_s !== 8'd3)
      $display("FAIL cooldown_hold: got cd %b elapsed %0d want 1 3", cooldown, elapsed_s); else n_pass++;
    step();
    n_total++; if (cooldown !== 1'b0 || grant !== 4'b0)
      $display("FAIL cooldown_exit: got cd %b grant %b want 0 0000", cooldown, grant); else n_pass++;
    repeat (4) step();
    n_total++; if (grant !== 4'b0) $display("FAIL idle_no_req: got %b want 0000", grant); else n_pass++;
  endtask

  task automatic test_contended;
    req = 4'b0110; tick_1s = 1'b1;
    exp_q.push_back(4'b0001 << rr_ref(req, model_last)); model_last = rr_ref(req, model_last);
    step();
    tick_1s = 1'b0;
    e = exp_q.pop_front();
    n_total++; if (grant !== e || e !== 4'b0010) $display("FAIL contended_grant: got %b want %b", grant, e); else n_pass++;
    n_total++; if (elapsed_s !== 8'd0) $display("FAIL entry_tick_lost: got %0d want 0", elapsed_s); else n_pass++;
    repeat (20) do_tick();
    n_total++; if (grant !== 4'b0010 || elapsed_s !== 8'd20)
      $display("FAIL max_on_hold: got grant %b elapsed %0d want 0010 20", grant, elapsed_s); else n_pass++;
    step();
    n_total++; if (grant !== 4'b0 || cooldown !== 1'b1)
      $display("FAIL max_on_release: got grant %b cd %b want 0000 1", grant, cooldown); else n_pass++;
    repeat (3) do_tick();
    n_total++; if (grant !== 4'b0) $display("FAIL cooldown_ignores_req: got %b want 0000", grant); else n_pass++;
    exp_q.push_back(4'b0100); model_last = 2'd2;
    step();
    n_total++; if (grant !== 4'b0 || cooldown !== 1'b0)
      $display("FAIL idle_gap: got grant %b cd %b want 0000 0", grant, cooldown); else n_pass++;
    step();
    e = exp_q.pop_front();
    n_total++; if (grant !== e || active_id !== 2'd2)
      $display("FAIL rr_after_cooldown: got %b id %0d want %b id 2", grant, active_id, e); else n_pass++;
  endtask

  task automatic test_long_hold;
    req = 4'b1000;
    repeat (5) do_tick();
    step();
    repeat (3) do_tick();
    exp_q.push_back(4'b1000); model_last = 2'd3;
    step();
    step();
    e = exp_q.pop_front();
    n_total++; if (grant !== e) $display("FAIL dehum_grant: got %b want %b", grant, e); else n_pass++;
    for (int i = 0; i < 40; i++) begin
      do_tick();
      n_total++; if (grant !== 4'b1000) $display("FAIL long_hold_t%0d: got %b want 1000", i, grant); else n_pass++;
    end
    n_total++; if (elapsed_s !== 8'd40) $display("FAIL long_hold_elapsed: got %0d want 40", elapsed_s); else n_pass++;
  endtask

  task automatic test_reset_mid_on;
    presetn = 1'b0;
    step();
    presetn = 1'b1; model_last = 2'd3;
    req = 4'b0100;
    exp_q.push_back(4'b0100); model_last = 2'd2;
    step();
    e = exp_q.pop_front();
    n_total++; if (grant !== e) $display("FAIL pre_reset_grant: got %b want %b", grant, e); else n_pass++;
    repeat (7) do_tick();
    n_total++; if (elapsed_s !== 8'd7) $display("FAIL pre_reset_elapsed: got %0d want 7", elapsed_s); else n_pass++;
    #2;
    presetn = 1'b0;
    #1;
    n_total++; if (grant !== 4'b0 || active_id !== 2'd3 || cooldown !== 1'b0 || elapsed_s !== 8'd0)
      $display("FAIL async_reset: got grant %b id %0d cd %b el %0d want 0000 3 0 0",
               grant, active_id, cooldown, elapsed_s); else n_pass++;
    step();
    presetn = 1'b1; model_last = 2'd3;
    req = 4'b1111;
    exp_q.push_back(4'b0001); model_last = 2'd0;
    step();
    e = exp_q.pop_front();
    n_total++; if (grant !== e || active_id !== 2'd0)
      $display("FAIL post_reset_grant: got %b id %0d want %b id 0", grant, active_id, e); else n_pass++;
  endtask

  task automatic test_soak;
    logic [3:0] prev_grant;
    logic [3:0] exp_g;
    logic [1:0] ch;
    int         on_ticks;
    bit         drained;
    req = 4'b0; drained = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (grant == 4'b0 && !cooldown) begin
        drained = 1'b1;
        break;
      end
      do_tick();
    end
    n_total++; if (!drained) $display("FAIL soak_drain: grant %b cd %b still busy after 200 cycles", grant, cooldown); else n_pass++;
    exp_q.delete();
    prev_grant = 4'b0; on_ticks = 0;
    for (int c = 0; c < 3000; c++) begin
      if (exp_q.size() != 0) begin
        exp_g = exp_q.pop_front();
        n_total++; if (grant !== exp_g) $display("FAIL soak_rr c%0d: got %b want %b", c, grant, exp_g); else n_pass++;
      end
      n_total++; if (!$onehot0(grant)) $display("FAIL soak_onehot0 c%0d: got %b want onehot0", c, grant); else n_pass++;
      n_total++; if (cooldown && grant != 4'b0) $display("FAIL soak_cd_grant c%0d: got %b want 0000", c, grant); else n_pass++;
      if (prev_grant != 4'b0 && grant == 4'b0) begin
        n_total++; if (on_ticks < MIN_ON_S) $display("FAIL soak_min_on c%0d: got %0d ticks want >= %0d", c, on_ticks, MIN_ON_S); else n_pass++;
      end
      if (grant == 4'b0) on_ticks = 0;
      if ($urandom_range(7) == 0) req = 4'($urandom_range(15));
      tick_1s = ($urandom_range(2) == 0);
      if (grant == 4'b0 && !cooldown && req != 4'b0) begin
        ch = rr_ref(req, model_last);
        exp_q.push_back(4'b0001 << ch);
        model_last = ch;
      end
      if (grant != 4'b0 && tick_1s) on_ticks++;
      prev_grant = grant;
      step();
    end
    tick_1s = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    test_reset();
    test_first_grant();
    test_min_on_hold();
    test_contended();
    test_long_hold();
    test_reset_mid_on();
    test_soak();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_total);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/env_act_sched.md
ENV_ACT_SCHED -- requirements
Module: env_act_sched

Interface
REQ-001 The block SHALL have parameter MIN_ON_S, default 5, minimum seconds a granted actuator stays on.
REQ-002 The block SHALL have parameter MAX_ON_S, default 20, on-time after which a contended grant is released.
REQ-003 The block SHALL have parameter MIN_OFF_S, default 3, mandatory all-off seconds between grants.
REQ-004 The block SHALL have parameter TIMER_W, default 8, width of the seconds counter.
REQ-005 The block SHALL have port pclk, input, 1 bit, the single clock.
REQ-006 The block SHALL have port presetn, input, 1 bit, asynchronous active-low reset.
REQ-007 The block SHALL have port tick_1s, input, 1 bit, one-pclk pulse per elapsed second.
REQ-008 The block SHALL have port req, input, 4 bits, actuator requests: bit0 heater, bit1 cooler, bit2 humidifier, bit3 dehumidifier.
REQ-009 The block SHALL have port grant, output, 4 bits, one-hot-or-zero actuator enable.
REQ-010 The block SHALL have port active_id, output, 2 bits, index of the current or last granted channel.
REQ-011 The block SHALL have port cooldown, output, 1 bit, high while in the all-off interval.
REQ-012 The block SHALL have port elapsed_s, output, TIMER_W bits, seconds elapsed in the current ON or COOLDOWN state.

Function
REQ-013 The state machine SHALL have three states, IDLE, ON and COOLDOWN, and all outputs SHALL be registered.
REQ-014 In IDLE with req nonzero, the block SHALL select a channel round-robin, searching from (active_id+1) mod 4 upward, and SHALL enter ON the next cycle with grant one-hot on that channel and active_id updated, giving 1-cycle latency.
REQ-015 In IDLE with req zero, the block SHALL remain in IDLE with grant=0.
REQ-016 elapsed_s SHALL clear on entry to ON or COOLDOWN, SHALL increment on each cycle with tick_1s=1, and SHALL saturate at 2^TIMER_W-1.
REQ-017 ON SHALL exit to COOLDOWN when elapsed_s>=MIN_ON_S and either req[active_id]=0, or elapsed_s>=MAX_ON_S with any other req bit high.
REQ-018 While elapsed_s<MIN_ON_S, grant SHALL hold even if req[active_id] drops.
REQ-019 With no other request pending, ON SHALL persist past MAX_ON_S for as long as req[active_id]=1.
REQ-020 COOLDOWN SHALL drive grant=0 and cooldown=1, and SHALL exit to IDLE when elapsed_s>=MIN_OFF_S.
REQ-021 Requests arriving during COOLDOWN SHALL be ignored until IDLE, and no channel SHALL ever be granted directly after another without COOLDOWN.
REQ-022 If tick_1s coincides with a state-entry cycle, the tick SHALL be lost, because the clear has priority.
REQ-023 At most one grant bit SHALL be high in any cycle.

Reset
REQ-024 presetn low SHALL asynchronously force IDLE, grant=0, cooldown=0, elapsed_s=0 and active_id=3, so that channel 0 wins first arbitration.
REQ-025 Reset asserted mid-ON SHALL drop grant in the same cycle with no cooldown enforced.

Structure
REQ-026 Package env_act_pkg SHALL hold the state enum, NUM_CH=4 and the channel index constants CH_HEAT, CH_COOL, CH_HUM and CH_DEHUM.
REQ-027 Sub-module env_act_rr_pick SHALL be a combinational round-robin picker with inputs req[3:0] and last_id[1:0], and outputs found and pick_id[1:0].
REQ-028 The state, active_id and elapsed_s registers SHALL reside in env_act_sched.

Verification (defaults MIN_ON_S=5, MAX_ON_S=20, MIN_OFF_S=3)
REQ-029 Reset then req=4'b0101 -> grant=4'b0001 one cycle later, active_id=0.
REQ-030 Heater granted, req[0] dropped after 2 ticks -> grant holds until elapsed_s=5, then cooldown=1 for 3 ticks, then IDLE.
REQ-031 req[1] held plus req[2] high continuously -> grant=4'b0010 released at elapsed_s=20, 3-tick cooldown, then grant=4'b0100.
REQ-032 req[3] alone held 40 ticks -> grant=4'b1000 stays on throughout, elapsed_s=40.
REQ-033 presetn pulsed low mid-ON at elapsed_s=7 -> grant=0 immediately, active_id=3, and req=4'b1111 after release -> grant=4'b0001.
REQ-034 The bench SHALL run a random req/tick soak with assertions: grant onehot0, no grant while cooldown=1, and every on-interval >= MIN_ON_S ticks.
